prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have one parameter: ADDR_W, default 5, meaning CPU memory address width (depth 2**ADDR_W = 32 bytes).
REQ-002 The module SHALL have an input port clock, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have an input port reset_n, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have an input port start, 1 bit, a one-cycle request to (re)load the program.
REQ-005 The module SHALL have an input port in_valid, 1 bit, meaning an upstream byte is present.
REQ-006 The module SHALL have an input port in_data, 8 bits, the upstream byte.
REQ-007 The module SHALL have an input port in_last, 1 bit, marking the current byte as the checksum byte that ends the stream.
REQ-008 The module SHALL have an output port in_ready, 1 bit, asserted when a byte will be accepted.
REQ-009 The module SHALL have an output port mem_we, 1 bit, the write strobe to the CPU 32x8 memory.
REQ-010 The module SHALL have an output port mem_addr, ADDR_W bits, the write address.
REQ-011 The module SHALL have an output port mem_wdata, 8 bits, the write data.
REQ-012 The module SHALL have an output port cpu_run, 1 bit, which releases the CPU to execute from address 0.
REQ-013 The module SHALL have an input port cpu_halted, 1 bit, asserted by the CPU on hlt.
REQ-014 The module SHALL have an output port err, 1 bit, a sticky load-failure flag.
REQ-015 The module SHALL have an output port byte_count, ADDR_W+1 bits, the number of data bytes written (0..32).

Function
REQ-016 The module SHALL implement the states IDLE, CLEAR, LOAD, RUN and ERROR, and all outputs SHALL be registered.
REQ-017 When start=1 in IDLE or ERROR, the module SHALL enter CLEAR, zero byte_count and the checksum accumulator, and clear err; start SHALL be ignored in CLEAR, LOAD and RUN.
REQ-018 In CLEAR, the module SHALL assert mem_we for exactly 32 consecutive cycles with mem_addr 0,1,...,31 and mem_wdata=0, then enter LOAD; in_ready SHALL be 0 throughout CLEAR.
REQ-019 In LOAD, the module SHALL hold in_ready=1, and a beat SHALL be accepted only on an edge where in_valid=1 and in_ready=1.
REQ-020 For an accepted beat with in_last=0 and byte_count<32, the module SHALL write in_data at address byte_count (mem_we high for one cycle, the cycle after acceptance), increment byte_count, and add in_data modulo 256 to the accumulator.
REQ-021 For an accepted beat with in_last=0 and byte_count=32, the module SHALL perform no write, enter ERROR and set err=1.
REQ-022 For an accepted beat with in_last=1, the module SHALL perform no write and compare in_data with the accumulator: equal enters RUN, unequal enters ERROR with err=1.
REQ-023 An in_last beat with no preceding data beats SHALL be checked against an accumulator of 0.
REQ-024 In RUN, the module SHALL hold cpu_run=1 and in_ready=0, and SHALL return to IDLE on the first edge with cpu_halted=1, with cpu_run=0 from the next cycle.
REQ-025 cpu_halted SHALL be ignored outside RUN.
REQ-026 In ERROR, the module SHALL hold err=1, cpu_run=0, in_ready=0 and mem_we=0 until start.
REQ-027 Idle cycles on in_valid in LOAD SHALL cause no write and no state change.

Reset
REQ-028 While reset_n=0, the module SHALL hold state=IDLE and in_ready, mem_we, cpu_run and err at 0, and mem_addr, mem_wdata, byte_count and the accumulator at 0.
REQ-029 Reset asserted in any state, including mid-CLEAR, mid-LOAD or RUN, SHALL abort immediately; memory contents already written are left as is.
REQ-030 After reset_n deasserts, the module SHALL stay in IDLE until start.

Verification
REQ-031 The bench SHALL cover a good load: start; 32 clear writes; bytes EF,01,00 then in_last byte F0 -> writes (0,EF),(1,01),(2,00), byte_count=3, cpu_run=1, err=0.
REQ-032 The bench SHALL cover a bad checksum: same stream with last byte 00 -> err=1, cpu_run=0; a following start -> err=0 and CLEAR restarts at address 0.
REQ-033 The bench SHALL cover overflow: 33 data bytes 01 -> 32 writes, byte_count=32, 33rd byte not written, err=1.
REQ-034 The bench SHALL cover backpressure: in_valid toggled 1,0,0,1 with data 0A,0B -> exactly 2 writes at addresses 0 and 1.
REQ-035 The bench SHALL cover halt: in RUN, drive cpu_halted=1 for one cycle -> cpu_run=0 next cycle, state IDLE, and start in RUN beforehand ignored.
REQ-036 The bench SHALL cover reset mid-CLEAR: reset_n=0 at mem_addr=10 -> mem_we=0 immediately, IDLE after release, no further writes without start.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: clears CPU memory, streams in a checksummed image,
// then releases the CPU until it halts.
module prog_loader #(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RUN,
    S_ERROR
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_A = '1;
  localparam logic [ADDR_W:0]   FULL   = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        acc_q, acc_d;

  logic beat;
  assign beat = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_run_d   = cpu_run_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d     = S_CLEAR;
          in_ready_d  = 1'b0;
          cpu_run_d   = 1'b0;
          err_d       = 1'b0;
          cnt_d       = '0;
          acc_d       = '0;
          mem_we_d    = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      S_CLEAR: begin
        // The write to the last address is already on the bus here.
        if (mem_addr_q == LAST_A) begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + 1'b1;
          mem_wdata_d = '0;
        end
      end
      S_LOAD: begin
        if (beat) begin
          if (in_last) begin
            in_ready_d = 1'b0;
            if (in_data == acc_q) begin
              state_d   = S_RUN;
              cpu_run_d = 1'b1;
            end else begin
              state_d = S_ERROR;
              err_d   = 1'b1;
            end
          end else if (cnt_q == FULL) begin
            state_d    = S_ERROR;
            in_ready_d = 1'b0;
            err_d      = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q[ADDR_W-1:0];
            mem_wdata_d = in_data;
            cnt_d       = cnt_q + 1'b1;
            acc_d       = acc_q + in_data;
          end
        end
      end
      S_RUN: begin
        if (cpu_halted) begin
          state_d   = S_IDLE;
          cpu_run_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign err        = err_q;
  assign byte_count = cnt_q;

endmodule
